sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one sram-like memory port between the fetch stage (inst master) and the exe/mem stages (data master).
- The data side drives the same data_sram signals the exe stage produces today, plus addr_ok/data_ok handshakes.
- Fixed data-over-inst priority; grant is held until the address handshake completes.
- An in-order outstanding-ID FIFO routes each data_ok/rdata response back to the master that issued it.

Parameters:
- OUTSTANDING, 2, max accepted-but-unanswered transactions (power of 2, >=1)
- ADDR_WD, 32, address/data width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  inst master request; held until inst_addr_ok
- inst_wr  in  1  write=1 / read=0
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  ADDR_WD  request address
- inst_wdata  in  ADDR_WD  write data
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response for the oldest inst transaction
- inst_rdata  out  ADDR_WD  read data, valid with inst_data_ok
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as inst_* for the data master
- sram_req  out  1  forwarded request
- sram_wr, sram_size, sram_addr, sram_wdata  out  1/2/ADDR_WD/ADDR_WD  muxed from the granted master
- sram_addr_ok  in  1  slave accepts the request
- sram_data_ok  in  1  slave response, in issue order
- sram_rdata  in  ADDR_WD  slave read data
- protocol_err  out  1  sticky: data_ok received with nothing outstanding

Behaviour:
- State:
  - lock_valid, lock_id (0=inst, 1=data)
  - ID FIFO of OUTSTANDING 1-bit entries: rd_ptr, wr_ptr, count 0..OUTSTANDING
  - protocol_err register
- Reset: all state and protocol_err go to 0; FIFO empty, no lock. Any in-flight transactions are discarded and later data_ok pulses are treated as spurious.
- Selection (combinational):
  - lock_valid ? lock_id : data_req ? 1 : inst_req ? 0 : none.
  - full = (count == OUTSTANDING).
- sram_req = selected master's req & !full. sram_wr/size/addr/wdata come from the selected master (data master when none is selected).
- Address handshake: hs = sram_req & sram_addr_ok.
  - Raise addr_ok only to the selected master, equal to hs; the other master sees 0. Pass-through is combinational, zero latency.
- Lock: if sram_req & !sram_addr_ok, set lock_valid=1 and lock_id=sel at the clock edge. Clear it on hs. While locked, a higher-priority data_req does not preempt; the sram_* outputs stay stable.
- Push: on hs, push sel into the FIFO at wr_ptr; wr_ptr wraps mod OUTSTANDING.
- Pop: on sram_data_ok & count!=0, pop the head; rd_ptr wraps.
  - inst_data_ok = pop & head==0; data_data_ok = pop & head==1.
  - sram_rdata is broadcast to both rdata outputs.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Full: when count==OUTSTANDING, sram_req=0 even if a pop occurs in the same cycle. Issue resumes the cycle after count drops. Full blocks issue but does not drop the lock.
- Spurious response: sram_data_ok with count==0 is ignored (no master data_ok). protocol_err is set and stays 1 until reset.
- Slave contract: data_ok arrives at least one cycle after its addr_ok.
- Latency: no added cycles on either the request or the response path.

Test Plan:
1. Inst-only read: inst_req=1, inst_addr=0xBFC00000; slave addr_ok in the same cycle, data_ok next cycle with rdata=0x3C080001 -> inst_addr_ok=1 for 1 cycle; inst_data_ok=1 and inst_rdata=0x3C080001 the next cycle; data_addr_ok and data_data_ok stay 0.
2. Contention: inst_req and data_req (addr 0x80001000) both asserted, slave always addr_ok=1 -> cycle0 sram_addr=0x80001000 with data_addr_ok=1; cycle1 the inst request is issued.
3. Lock: inst request presented, slave withholds addr_ok 3 cycles, data_req rises in cycle 1 -> sram_addr stays at the inst address through the handshake in cycle 3; data is issued in cycle 4.
4. Full (OUTSTANDING=2): two handshakes with no data_ok -> third request sees sram_req=0. A data_ok in cycle N still gives sram_req=0 in cycle N; the request is issued in N+1.
5. Ordering: data write then inst read accepted; two data_ok pulses with rdata 0x0/0x12345678 -> first raises data_data_ok, second raises inst_data_ok with inst_rdata=0x12345678.
6. Errors and reset: sram_data_ok with FIFO empty -> no master data_ok, protocol_err=1 held. Reset with 2 outstanding -> count=0, protocol_err=0, and the next data_ok sets protocol_err.

Source files
------------

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_arbiter
// Description : Shares one sram-like port between an instruction master and a
//               data master. Data wins over inst, a grant is held until the
//               address handshake completes, and an in-order ID FIFO routes
//               each response back to the master that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_WD     = 32
) (
  input  logic               clk,
  input  logic               reset,
  // instruction master
  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [1:0]         inst_size,
  input  logic [ADDR_WD-1:0] inst_addr,
  input  logic [ADDR_WD-1:0] inst_wdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [ADDR_WD-1:0] inst_rdata,
  // data master
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [1:0]         data_size,
  input  logic [ADDR_WD-1:0] data_addr,
  input  logic [ADDR_WD-1:0] data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [ADDR_WD-1:0] data_rdata,
  // shared slave port
  output logic               sram_req,
  output logic               sram_wr,
  output logic [1:0]         sram_size,
  output logic [ADDR_WD-1:0] sram_addr,
  output logic [ADDR_WD-1:0] sram_wdata,
  input  logic               sram_addr_ok,
  input  logic               sram_data_ok,
  input  logic [ADDR_WD-1:0] sram_rdata,
  // status
  output logic               protocol_err
);

  // Pointer width; a single-entry FIFO still needs a 1-bit pointer that stays 0.
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int DEPTH = 1 << PTR_W;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  // Master identity as stored in the lock and the ID FIFO.
  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } master_id_e;

  // Grant lock: held while the slave is stalling the address handshake.
  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

  lock_state_e             lock_q,   lock_d;
  master_id_e              lock_id_q, lock_id_d;
  logic [DEPTH-1:0]        fifo_q,   fifo_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q,  count_d;
  logic                    perr_q,   perr_d;

  master_id_e              sel_id;
  logic                    sel_req;
  logic                    full;
  logic                    hs;
  logic                    pop;
  logic                    head;

  // Wrapping pointer increment; handles non-trivial wrap for OUTSTANDING=1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Master selection: a held lock wins, otherwise data over inst.
  always_comb begin
    sel_id = ID_DATA;
    if (lock_q == LK_HELD) begin
      sel_id = lock_id_q;
    end else if (data_req) begin
      sel_id = ID_DATA;
    end else if (inst_req) begin
      sel_id = ID_INST;
    end
    sel_req = (sel_id == ID_DATA) ? data_req : inst_req;
  end

  assign full = (count_q == CNT_FULL);
  assign hs   = sram_req & sram_addr_ok;
  assign pop  = sram_data_ok & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  // Request path: forward the selected master with zero added latency.
  always_comb begin
    sram_req     = sel_req & ~full;
    sram_wr      = data_wr;
    sram_size    = data_size;
    sram_addr    = data_addr;
    sram_wdata   = data_wdata;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (sel_id == ID_INST) begin
      sram_wr      = inst_wr;
      sram_size    = inst_size;
      sram_addr    = inst_addr;
      sram_wdata   = inst_wdata;
      inst_addr_ok = hs;
    end else begin
      data_addr_ok = hs;
    end
  end

  // Response path: route data_ok by the oldest outstanding ID, broadcast rdata.
  always_comb begin
    inst_data_ok = pop & (head == ID_INST);
    data_data_ok = pop & (head == ID_DATA);
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
    protocol_err = perr_q;
  end

  // Next-state for lock, ID FIFO, occupancy and the sticky error flag.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    perr_d    = perr_q;

    // A stalled request keeps the grant so the slave sees stable signals.
    if (hs) begin
      lock_d = LK_FREE;
    end else if (sram_req) begin
      lock_d    = LK_HELD;
      lock_id_d = sel_id;
    end

    if (hs) begin
      fifo_d[wr_ptr_q] = sel_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({hs, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A response with nothing outstanding is a slave protocol violation.
    if (sram_data_ok && (count_q == '0)) begin
      perr_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset discards in-flight IDs.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= LK_FREE;
      lock_id_q <= ID_INST;
      fifo_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      perr_q    <= perr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_req_arbiter
// Description : Self-checking bench for sram_req_arbiter: directed scenarios
//               followed by randomized masters/slave against a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

  localparam int OUTSTANDING = 2;
  localparam int AW          = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr, inst_wdata, inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr, data_wdata, data_rdata;
  logic          sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [1:0]    sram_size;
  logic [AW-1:0] sram_addr, sram_wdata, sram_rdata;
  logic          protocol_err;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(OUTSTANDING), .ADDR_WD(AW)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .protocol_err(protocol_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: who owns a stalled request, outstanding issuers in order,
  // and whether a stray response has been seen since reset.
  int m_owner = -1;
  int m_q[$];
  bit m_err   = 1'b0;
  bit m_hs_inst = 1'b0;
  bit m_hs_data = 1'b0;

  task automatic eval();
    int            sel;
    int            head;
    bit            full, sreq, hs, pop;
    logic          ewr;
    logic [1:0]    esz;
    logic [AW-1:0] ea, ewd;
    #1;
    if (m_owner >= 0)  sel = m_owner;
    else if (data_req) sel = 1;
    else if (inst_req) sel = 0;
    else               sel = -1;
    full = (m_q.size() == OUTSTANDING);
    sreq = ((sel == 1 && data_req) || (sel == 0 && inst_req)) && !full;
    hs   = sreq && sram_addr_ok;
    pop  = sram_data_ok && (m_q.size() > 0);
    head = pop ? m_q[0] : -1;
    if (sel == 0) begin ewr = inst_wr; esz = inst_size; ea = inst_addr; ewd = inst_wdata; end
    else          begin ewr = data_wr; esz = data_size; ea = data_addr; ewd = data_wdata; end

    chk("sram_req",     sram_req,     sreq);
    chk("sram_wr",      sram_wr,      ewr);
    chk("sram_size",    sram_size,    esz);
    chk("sram_addr",    sram_addr,    ea);
    chk("sram_wdata",   sram_wdata,   ewd);
    chk("inst_addr_ok", inst_addr_ok, hs && sel == 0);
    chk("data_addr_ok", data_addr_ok, hs && sel == 1);
    chk("inst_data_ok", inst_data_ok, head == 0);
    chk("data_data_ok", data_data_ok, head == 1);
    chk("inst_rdata",   inst_rdata,   sram_rdata);
    chk("data_rdata",   data_rdata,   sram_rdata);
    chk("protocol_err", protocol_err, m_err);

    m_hs_inst = hs && sel == 0;
    m_hs_data = hs && sel == 1;
    if (reset) begin
      m_owner = -1;
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (sram_data_ok && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(sel);
        m_owner = -1;
      end else if (sreq) begin
        m_owner = sel;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; sram_addr_ok = 0; sram_data_ok = 0;
  endtask

  int pend;

  initial begin
    reset = 1; idle_inputs();
    inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wdata = 0;
    data_wr = 0; data_size = 2; data_addr = 0; data_wdata = 0; sram_rdata = 0;
    repeat (2) @(negedge clk);
    reset = 0;

    // Inst-only read with same-cycle accept and next-cycle response.
    inst_req = 1; inst_addr = 32'hBFC00000; sram_addr_ok = 1;
    eval();
    chk("p1_iaok", inst_addr_ok, 1); chk("p1_addr", sram_addr, 32'hBFC00000);
    chk("p1_daok", data_addr_ok, 0);
    tick();
    inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h3C080001;
    eval();
    chk("p1_idok", inst_data_ok, 1); chk("p1_rdata", inst_rdata, 32'h3C080001);
    chk("p1_ddok", data_data_ok, 0);
    tick(); sram_data_ok = 0;

    // Contention: data first, inst next cycle.
    inst_req = 1; data_req = 1; data_addr = 32'h80001000; sram_addr_ok = 1;
    eval(); chk("p2_daddr", sram_addr, 32'h80001000); chk("p2_daok", data_addr_ok, 1);
    tick(); data_req = 0;
    eval(); chk("p2_iaok", inst_addr_ok, 1);
    tick(); inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
    eval(); tick(); eval(); tick(); sram_data_ok = 0;

    // Lock: inst stalled 3 cycles, data arrives meanwhile and must wait.
    inst_req = 1; inst_addr = 32'h00000400;
    eval(); tick();
    data_req = 1; data_addr = 32'h00000800;
    eval(); chk("p3_hold1", sram_addr, 32'h00000400); tick();
    eval(); chk("p3_hold2", sram_addr, 32'h00000400); tick();
    sram_addr_ok = 1;
    eval(); chk("p3_iaok", inst_addr_ok, 1); tick();
    inst_req = 0;
    eval(); chk("p3_daok", data_addr_ok, 1); chk("p3_daddr", sram_addr, 32'h00000800); tick();
    data_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
    eval(); tick(); eval(); tick(); sram_data_ok = 0;

    // Full: third request blocked even in the cycle a response frees a slot.
    data_req = 1; data_addr = 32'h100; sram_addr_ok = 1;
    eval(); tick(); data_addr = 32'h104;
    eval(); tick(); data_addr = 32'h108;
    eval(); chk("p4_full", sram_req, 0); tick();
    sram_data_ok = 1;
    eval(); chk("p4_fullpop", sram_req, 0); chk("p4_dok", data_data_ok, 1); tick();
    sram_data_ok = 0;
    eval(); chk("p4_resume", data_addr_ok, 1); tick();
    data_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
    eval(); tick(); eval(); tick(); sram_data_ok = 0;

    // Ordering: data write then inst read; responses routed in issue order.
    data_req = 1; data_wr = 1; data_addr = 32'h200; sram_addr_ok = 1;
    eval(); tick();
    data_req = 0; data_wr = 0; inst_req = 1; inst_addr = 32'h300;
    eval(); tick();
    inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h0;
    eval(); chk("p5_first", data_data_ok, 1); tick();
    sram_rdata = 32'h12345678;
    eval(); chk("p5_second", inst_data_ok, 1); chk("p5_rdata", inst_rdata, 32'h12345678); tick();
    sram_data_ok = 0;

    // Spurious response sets a sticky error; reset clears it and drops IDs.
    sram_data_ok = 1;
    eval(); chk("p6_idok", inst_data_ok, 0); chk("p6_ddok", data_data_ok, 0); tick();
    sram_data_ok = 0;
    eval(); chk("p6_err", protocol_err, 1); tick();
    eval(); chk("p6_sticky", protocol_err, 1); tick();
    data_req = 1; sram_addr_ok = 1;
    eval(); tick(); eval(); tick();
    data_req = 0; sram_addr_ok = 0; reset = 1;
    eval(); tick();
    reset = 0; sram_data_ok = 1;
    eval(); chk("p6_clr", protocol_err, 0); chk("p6_spur", data_data_ok, 0); tick();
    sram_data_ok = 0;
    eval(); chk("p6_reerr", protocol_err, 1); tick();
    reset = 1; eval(); tick(); reset = 0;

    // Randomized masters and slave against the reference model.
    idle_inputs(); m_hs_inst = 0; m_hs_data = 0; pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!inst_req || m_hs_inst) begin
        inst_req = ($urandom_range(0, 99) < 40); inst_wr = 1'($urandom);
        inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!data_req || m_hs_data) begin
        data_req = ($urandom_range(0, 99) < 50); data_wr = 1'($urandom);
        data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
      end
      sram_addr_ok = ($urandom_range(0, 99) < 55);
      sram_data_ok = (pend > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
      sram_rdata   = $urandom;
      reset        = ($urandom_range(0, 299) == 0);
      eval();
      if (reset) pend = 0;
      else begin
        if (sram_data_ok && pend > 0) pend--;
        if (m_hs_inst || m_hs_data) pend++;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
